// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between N requesting agents and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_req_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = 2
) ();
    logic            en;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;
    logic            timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_vld, timeout
    );
endinterface

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: rotating-priority pick, grant held until done/withdraw,
// optional hold timeout forcing release so no owner can starve the others.
module rr_req_arbiter #(
    parameter int N        = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 15,
    parameter int CNTW     = 4
) (
    input logic             clk,
    input logic             rst_n,
    rr_req_arbiter_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [IDXW-1:0] r_gnt_idx;
    logic [IDXW-1:0] r_ptr;
    logic            r_gnt_vld;
    logic            r_timeout;
    logic [CNTW-1:0] r_hold_cnt;

    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic            w_any;
    logic [IDXW-1:0] w_off;
    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_win_idx;
    logic [N-1:0]    w_win_oh;
    logic            w_rel_done;
    logic            w_rel_wd;
    logic            w_rel_to;
    logic            w_release;
    logic [IDXW-1:0] w_ptr_next;

    // Rotate req so that bit 0 is the requester at ptr; the first set bit of the
    // rotated vector is then the winner's offset from ptr.
    assign w_dbl = {bus.req, bus.req} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_off = IDXW'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win_idx = (w_sum >= (IDXW+1)'(N)) ? IDXW'(w_sum - (IDXW+1)'(N)) : IDXW'(w_sum);
    assign w_win_oh  = N'(1) << w_win_idx;

    assign w_rel_done = bus.done;
    assign w_rel_wd   = ~|(bus.req & r_gnt);
    assign w_rel_to   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release  = w_rel_done || w_rel_wd || w_rel_to;
    assign w_ptr_next = (r_gnt_idx == IDXW'(N - 1)) ? '0 : r_gnt_idx + IDXW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout <= 1'b0;
                    if (bus.en && w_any) begin
                        r_state    <= S_GRANT;
                        r_gnt      <= w_win_oh;
                        r_gnt_idx  <= w_win_idx;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state    <= S_IDLE;
                        r_gnt      <= '0;
                        r_gnt_idx  <= '0;
                        r_gnt_vld  <= 1'b0;
                        r_ptr      <= w_ptr_next;
                        r_hold_cnt <= '0;
                        // Timeout is reported only when nothing else would have released.
                        r_timeout  <= w_rel_to && !w_rel_done && !w_rel_wd;
                    end else begin
                        r_timeout <= 1'b0;
                        if (r_hold_cnt != '1) begin
                            r_hold_cnt <= r_hold_cnt + CNTW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.timeout = r_timeout;

endmodule
